// File: rtl/cs_loop_pkg.sv
// Shared types and defaults for the current-source loop lock sequencer.
// The state encoding is visible on the STATE port, so the values are fixed.
package cs_loop_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_COARSE = 3'd2,
      ST_FINE   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAILED = 3'd5
   } cs_state_e;

   localparam int unsigned DEF_SETTLE_WIN    = 4;
   localparam int unsigned DEF_COARSE_WIN    = 4;
   localparam int unsigned DEF_LOCK_WIN      = 8;
   localparam int unsigned DEF_UNLOCK_WIN    = 2;
   localparam int unsigned DEF_TIMEOUT_WIN   = 255;
   localparam int unsigned DEF_COARSE_MARGIN = 8;
   localparam int unsigned DEF_FINE_MARGIN   = 2;

   localparam logic [7:0] BOUND_OPEN_LO = 8'h00;
   localparam logic [7:0] BOUND_OPEN_HI = 8'hFF;

   // Inclusive window test used for both the coarse and fine bands.
   function automatic logic in_band(input logic [7:0] v,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/cs_bound_calc.sv
// Saturating target +/- margin window bounds, computed in 9 bits.
// Bit 8 of each result flags borrow (lower) or carry (upper).
module cs_bound_calc
   import cs_loop_pkg::*;
#(
   parameter int unsigned MARGIN = DEF_COARSE_MARGIN
) (
   input  logic [7:0] target_i,
   output logic [7:0] lower_o,
   output logic [7:0] upper_o
);

   localparam logic [8:0] MARGIN9 = 9'(MARGIN);

   logic [8:0] sum;
   logic [8:0] dif;

   always_comb begin
      sum     = {1'b0, target_i} + MARGIN9;
      dif     = {1'b0, target_i} - MARGIN9;
      lower_o = dif[8] ? '0 : dif[7:0];
      upper_o = sum[8] ? '1 : sum[7:0];
   end

endmodule

// File: rtl/cs_loop_sequencer.sv
// Lock sequencer: preset, bypass-settle, coarse and fine regulation, lock,
// with unlock/relock tracking and a window-count timeout.
module cs_loop_sequencer
   import cs_loop_pkg::*;
#(
   parameter int unsigned SETTLE_WIN    = DEF_SETTLE_WIN,
   parameter int unsigned COARSE_WIN    = DEF_COARSE_WIN,
   parameter int unsigned LOCK_WIN      = DEF_LOCK_WIN,
   parameter int unsigned UNLOCK_WIN    = DEF_UNLOCK_WIN,
   parameter int unsigned TIMEOUT_WIN   = DEF_TIMEOUT_WIN,
   parameter int unsigned COARSE_MARGIN = DEF_COARSE_MARGIN,
   parameter int unsigned FINE_MARGIN   = DEF_FINE_MARGIN
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic        ABORT,
   input  logic [7:0]  TARGET_COUNT,
   input  logic [31:0] CS_INIT,
   input  logic        COUNT_DONE,
   input  logic [7:0]  COUNTER,
   output logic        LOOP_BYPASS,
   output logic [7:0]  LOWER_VOLTAGE_BOUND,
   output logic [7:0]  UPPER_VOLTAGE_BOUND,
   output logic [31:0] NO_CURRENT_SOURCE,
   output logic        LOCKED,
   output logic        FAIL,
   output logic        BUSY,
   output logic [2:0]  STATE,
   output logic [3:0]  RELOCK_CNT
);

   cs_state_e   state_q;
   logic [7:0]  target_q;
   logic [31:0] cs_init_q;
   logic [7:0]  win_cnt_q;
   logic [7:0]  tmo_cnt_q;
   logic [1:0]  unl_cnt_q;
   logic [3:0]  relock_q;
   logic        locked_q;
   logic        fail_q;
   logic        busy_q;
   logic        bypass_q;
   logic [7:0]  lower_q;
   logic [7:0]  upper_q;
   logic [31:0] ncs_q;

   logic [7:0] coarse_lo, coarse_hi;
   logic [7:0] fine_lo, fine_hi;

   cs_bound_calc #(.MARGIN(COARSE_MARGIN)) u_coarse_bounds (
      .target_i (target_q),
      .lower_o  (coarse_lo),
      .upper_o  (coarse_hi)
   );

   cs_bound_calc #(.MARGIN(FINE_MARGIN)) u_fine_bounds (
      .target_i (target_q),
      .lower_o  (fine_lo),
      .upper_o  (fine_hi)
   );

   logic [7:0] win_inc;
   logic [7:0] tmo_inc;
   logic [1:0] unl_inc;
   logic [3:0] relock_inc;
   logic       drv_in_band;
   logic       coarse_in_band;

   // Regulation tests the bounds on the pins; the lock watchdog tests the
   // coarse band even though the fine bounds are driven while locked.
   always_comb begin
      win_inc        = win_cnt_q + 8'd1;
      tmo_inc        = tmo_cnt_q + 8'd1;
      unl_inc        = unl_cnt_q + 2'd1;
      relock_inc     = (relock_q == 4'hF) ? relock_q : relock_q + 4'd1;
      drv_in_band    = in_band(COUNTER, lower_q, upper_q);
      coarse_in_band = in_band(COUNTER, coarse_lo, coarse_hi);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         target_q  <= '0;
         cs_init_q <= '0;
         win_cnt_q <= '0;
         tmo_cnt_q <= '0;
         unl_cnt_q <= '0;
         relock_q  <= '0;
         locked_q  <= 1'b0;
         fail_q    <= 1'b0;
         busy_q    <= 1'b0;
         bypass_q  <= 1'b1;
         lower_q   <= BOUND_OPEN_LO;
         upper_q   <= BOUND_OPEN_HI;
         ncs_q     <= '0;
      end else if (ABORT) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         bypass_q <= 1'b1;
         lower_q  <= BOUND_OPEN_LO;
         upper_q  <= BOUND_OPEN_HI;
         ncs_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAILED: begin
               if (START) begin
                  state_q   <= ST_INIT;
                  target_q  <= TARGET_COUNT;
                  cs_init_q <= CS_INIT;
                  ncs_q     <= CS_INIT;
                  win_cnt_q <= '0;
                  tmo_cnt_q <= '0;
                  unl_cnt_q <= '0;
                  relock_q  <= '0;
                  locked_q  <= 1'b0;
                  fail_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  bypass_q  <= 1'b1;
                  lower_q   <= BOUND_OPEN_LO;
                  upper_q   <= BOUND_OPEN_HI;
               end
            end

            ST_INIT: begin
               if (COUNT_DONE) begin
                  if (win_inc == 8'(SETTLE_WIN)) begin
                     state_q   <= ST_COARSE;
                     win_cnt_q <= '0;
                     tmo_cnt_q <= '0;
                     bypass_q  <= 1'b0;
                     lower_q   <= coarse_lo;
                     upper_q   <= coarse_hi;
                  end else begin
                     win_cnt_q <= win_inc;
                  end
               end
            end

            ST_COARSE, ST_FINE: begin
               if (COUNT_DONE) begin
                  tmo_cnt_q <= tmo_inc;
                  // Completing the run takes precedence over the timeout.
                  if (drv_in_band && (state_q == ST_COARSE) &&
                      (win_inc == 8'(COARSE_WIN))) begin
                     state_q   <= ST_FINE;
                     win_cnt_q <= '0;
                     lower_q   <= fine_lo;
                     upper_q   <= fine_hi;
                  end else if (drv_in_band && (state_q == ST_FINE) &&
                               (win_inc == 8'(LOCK_WIN))) begin
                     state_q   <= ST_LOCKED;
                     win_cnt_q <= '0;
                     unl_cnt_q <= '0;
                     locked_q  <= 1'b1;
                     busy_q    <= 1'b0;
                  end else if (tmo_inc == 8'(TIMEOUT_WIN)) begin
                     state_q  <= ST_FAILED;
                     fail_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     bypass_q <= 1'b1;
                     lower_q  <= BOUND_OPEN_LO;
                     upper_q  <= BOUND_OPEN_HI;
                     ncs_q    <= cs_init_q;
                  end else begin
                     win_cnt_q <= drv_in_band ? win_inc : '0;
                  end
               end
            end

            ST_LOCKED: begin
               if (COUNT_DONE) begin
                  if (coarse_in_band) begin
                     unl_cnt_q <= '0;
                  end else if (unl_inc == 2'(UNLOCK_WIN)) begin
                     state_q   <= ST_COARSE;
                     unl_cnt_q <= '0;
                     win_cnt_q <= '0;
                     tmo_cnt_q <= '0;
                     relock_q  <= relock_inc;
                     locked_q  <= 1'b0;
                     busy_q    <= 1'b1;
                     lower_q   <= coarse_lo;
                     upper_q   <= coarse_hi;
                  end else begin
                     unl_cnt_q <= unl_inc;
                  end
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign LOOP_BYPASS         = bypass_q;
   assign LOWER_VOLTAGE_BOUND = lower_q;
   assign UPPER_VOLTAGE_BOUND = upper_q;
   assign NO_CURRENT_SOURCE   = ncs_q;
   assign LOCKED              = locked_q;
   assign FAIL                = fail_q;
   assign BUSY                = busy_q;
   assign STATE               = state_q;
   assign RELOCK_CNT          = relock_q;

endmodule

// File: tb/tb_cs_loop_sequencer.sv
// Self-checking bench for cs_loop_sequencer: a behavioural model pushes the
// expected outputs for every cycle; they are popped and compared after the edge.
module tb_cs_loop_sequencer;
   import cs_loop_pkg::*;

   localparam int SW = 4;
   localparam int CW = 4;
   localparam int LW = 8;
   localparam int UW = 2;
   localparam int TW = 255;
   localparam int CM = 8;
   localparam int FM = 2;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        START, ABORT, COUNT_DONE;
   logic [7:0]  TARGET_COUNT, COUNTER;
   logic [31:0] CS_INIT;
   logic        LOOP_BYPASS, LOCKED, fail_o, BUSY;
   logic [7:0]  LOWER_VOLTAGE_BOUND, UPPER_VOLTAGE_BOUND;
   logic [31:0] NO_CURRENT_SOURCE;
   logic [2:0]  STATE;
   logic [3:0]  RELOCK_CNT;

   always #5 CLK = ~CLK;

   cs_loop_sequencer #(
      .SETTLE_WIN(SW), .COARSE_WIN(CW), .LOCK_WIN(LW), .UNLOCK_WIN(UW),
      .TIMEOUT_WIN(TW), .COARSE_MARGIN(CM), .FINE_MARGIN(FM)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
      .TARGET_COUNT(TARGET_COUNT), .CS_INIT(CS_INIT),
      .COUNT_DONE(COUNT_DONE), .COUNTER(COUNTER),
      .LOOP_BYPASS(LOOP_BYPASS),
      .LOWER_VOLTAGE_BOUND(LOWER_VOLTAGE_BOUND),
      .UPPER_VOLTAGE_BOUND(UPPER_VOLTAGE_BOUND),
      .NO_CURRENT_SOURCE(NO_CURRENT_SOURCE),
      .LOCKED(LOCKED), .FAIL(fail_o), .BUSY(BUSY),
      .STATE(STATE), .RELOCK_CNT(RELOCK_CNT)
   );

   typedef struct packed {
      logic [2:0]  st;
      logic        byp;
      logic        lk;
      logic        fl;
      logic        bz;
      logic [3:0]  rc;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [31:0] ncs;
      logic        ck_b;
      logic        ck_n;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_bad = 0;

   // Model state: 0 idle, 1 init, 2 coarse, 3 fine, 4 locked, 5 failed.
   int          m_state, m_t, m_win, m_tmo, m_unl, m_rel;
   logic [31:0] m_cs;
   logic        m_locked, m_fail, m_busy;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat_lo(input int t, input int m);
      if (t < m) return 0;
      return t - m;
   endfunction

   function automatic int sat_hi(input int t, input int m);
      if (t + m > 255) return 255;
      return t + m;
   endfunction

   task automatic model_reset();
      m_state = 0; m_t = 0; m_win = 0; m_tmo = 0; m_unl = 0; m_rel = 0;
      m_cs = '0; m_locked = 0; m_fail = 0; m_busy = 0;
   endtask

   task automatic model_step(input logic st, input logic ab, input logic cd,
                             input int cnt);
      bit inb;
      if (ab) begin
         m_state = 0;
         m_busy  = 0;
         return;
      end
      case (m_state)
         0, 5: if (st) begin
            m_state = 1; m_t = int'(TARGET_COUNT); m_cs = CS_INIT;
            m_win = 0; m_tmo = 0; m_unl = 0; m_rel = 0;
            m_locked = 0; m_fail = 0; m_busy = 1;
         end
         1: if (cd) begin
            m_win++;
            if (m_win == SW) begin m_state = 2; m_win = 0; m_tmo = 0; end
         end
         2, 3: if (cd) begin
            m_tmo++;
            if (m_state == 2)
               inb = (cnt >= sat_lo(m_t, CM)) && (cnt <= sat_hi(m_t, CM));
            else
               inb = (cnt >= sat_lo(m_t, FM)) && (cnt <= sat_hi(m_t, FM));
            m_win = inb ? m_win + 1 : 0;
            if (m_state == 2 && m_win == CW) begin
               m_state = 3; m_win = 0;
            end else if (m_state == 3 && m_win == LW) begin
               m_state = 4; m_win = 0; m_unl = 0; m_locked = 1; m_busy = 0;
            end else if (m_tmo == TW) begin
               m_state = 5; m_fail = 1; m_busy = 0;
            end
         end
         4: if (cd) begin
            if (cnt < sat_lo(m_t, CM) || cnt > sat_hi(m_t, CM)) begin
               m_unl++;
               if (m_unl == UW) begin
                  m_state = 2; m_locked = 0; m_busy = 1;
                  if (m_rel < 15) m_rel++;
                  m_tmo = 0; m_win = 0; m_unl = 0;
               end
            end else begin
               m_unl = 0;
            end
         end
         default: ;
      endcase
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e = '0;
      e.st = 3'(m_state); e.lk = m_locked; e.fl = m_fail; e.bz = m_busy;
      e.rc = 4'(m_rel);
      case (m_state)
         0: begin
            e.byp = 1; e.lo = 8'h00; e.hi = 8'hFF; e.ncs = '0;
            e.ck_b = 1; e.ck_n = 1;
         end
         1, 5: begin e.byp = 1; e.ncs = m_cs; e.ck_n = 1; end
         2: begin
            e.lo = 8'(sat_lo(m_t, CM)); e.hi = 8'(sat_hi(m_t, CM)); e.ck_b = 1;
         end
         default: begin
            e.lo = 8'(sat_lo(m_t, FM)); e.hi = 8'(sat_hi(m_t, FM)); e.ck_b = 1;
         end
      endcase
      return e;
   endfunction

   task automatic compare(input exp_t e);
      check_eq("sb_state",  STATE,       e.st);
      check_eq("sb_bypass", LOOP_BYPASS, e.byp);
      check_eq("sb_locked", LOCKED,      e.lk);
      check_eq("sb_fail",   fail_o,      e.fl);
      check_eq("sb_busy",   BUSY,        e.bz);
      check_eq("sb_relock", RELOCK_CNT,  e.rc);
      if (e.ck_b) begin
         check_eq("sb_lower", LOWER_VOLTAGE_BOUND, e.lo);
         check_eq("sb_upper", UPPER_VOLTAGE_BOUND, e.hi);
      end
      if (e.ck_n) check_eq("sb_ncs", NO_CURRENT_SOURCE, e.ncs);
   endtask

   task automatic cyc(input logic st, input logic ab, input logic cd,
                      input logic [7:0] cnt);
      START = st; ABORT = ab; COUNT_DONE = cd; COUNTER = cnt;
      model_step(st, ab, cd, int'(cnt));
      sb_q.push_back(model_out());
      @(posedge CLK);
      #1;
      START = 0; ABORT = 0; COUNT_DONE = 0;
      compare(sb_q.pop_front());
   endtask

   task automatic window(input logic [7:0] cnt);
      cyc(0, 0, 1, cnt);
      cyc(0, 0, 0, cnt);
   endtask

   task automatic begin_seq(input logic [7:0] t, input logic [31:0] cs);
      TARGET_COUNT = t;
      CS_INIT      = cs;
      cyc(1, 0, 0, 8'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_state"},  STATE, 3'd0);
      check_eq({tag, "_bypass"}, LOOP_BYPASS, 1'b1);
      check_eq({tag, "_lower"},  LOWER_VOLTAGE_BOUND, 8'h00);
      check_eq({tag, "_upper"},  UPPER_VOLTAGE_BOUND, 8'hFF);
      check_eq({tag, "_ncs"},    NO_CURRENT_SOURCE, 32'h0);
      check_eq({tag, "_flags"},  {LOCKED, fail_o, BUSY}, 3'b000);
      check_eq({tag, "_relock"}, RELOCK_CNT, 4'd0);
   endtask

   initial begin
      RST_N = 0; START = 0; ABORT = 0; COUNT_DONE = 0;
      COUNTER = '0; TARGET_COUNT = '0; CS_INIT = '0;
      model_reset();
      #12;
      check_reset_values("rst");
      @(posedge CLK); #3; RST_N = 1;

      // Nominal lock, target 100, COUNT_DONE coincident with START ignored
      TARGET_COUNT = 8'd100; CS_INIT = 32'hA5A5_0F0F;
      cyc(1, 0, 1, 8'd100);
      for (int w = 1; w <= 16; w++) begin
         window(8'd100);
         if (w == 3) check_eq("nom_still_init", STATE, 3'd1);
         if (w == 4) begin
            check_eq("nom_coarse_lo", LOWER_VOLTAGE_BOUND, 8'd92);
            check_eq("nom_coarse_hi", UPPER_VOLTAGE_BOUND, 8'd108);
         end
         if (w == 8) begin
            check_eq("nom_fine_lo", LOWER_VOLTAGE_BOUND, 8'd98);
            check_eq("nom_fine_hi", UPPER_VOLTAGE_BOUND, 8'd102);
         end
         if (w == 15) check_eq("nom_not_yet", LOCKED, 1'b0);
      end
      check_eq("nom_locked", {LOCKED, BUSY}, 2'b10);
      cyc(1, 0, 0, 8'd100);
      check_eq("nom_start_ignored", STATE, 3'd4);

      // Unlock / relock
      window(8'd120);
      window(8'd100);
      check_eq("unl_single_keeps", LOCKED, 1'b1);
      window(8'd120);
      window(8'd120);
      check_eq("unl_state", STATE, 3'd2);
      check_eq("unl_relock", {LOCKED, RELOCK_CNT}, 5'b0_0001);
      cyc(0, 1, 0, 8'd0);

      // Saturation at both ends
      begin_seq(8'd3, 32'h0000_0003);
      for (int w = 0; w < SW; w++) window(8'd3);
      check_eq("sat3_coarse", {LOWER_VOLTAGE_BOUND, UPPER_VOLTAGE_BOUND}, 16'h000B);
      for (int w = 0; w < CW; w++) window(8'd3);
      check_eq("sat3_fine", {LOWER_VOLTAGE_BOUND, UPPER_VOLTAGE_BOUND}, 16'h0105);
      cyc(0, 1, 0, 8'd0);
      begin_seq(8'd250, 32'hFFFF_0000);
      for (int w = 0; w < SW; w++) window(8'd250);
      check_eq("sat250_coarse", {LOWER_VOLTAGE_BOUND, UPPER_VOLTAGE_BOUND}, 16'hF2FF);
      for (int w = 0; w < CW; w++) window(8'd255);
      check_eq("sat250_fine", {LOWER_VOLTAGE_BOUND, UPPER_VOLTAGE_BOUND}, 16'hF8FC);
      cyc(0, 1, 0, 8'd0);

      // Run reset in FINE
      begin_seq(8'd100, 32'h1234_5678);
      for (int w = 0; w < SW + CW + 7; w++) window(8'd100);
      window(8'd110);
      for (int w = 0; w < 7; w++) window(8'd101);
      check_eq("runrst_not_locked", LOCKED, 1'b0);
      window(8'd99);
      check_eq("runrst_locked", LOCKED, 1'b1);
      cyc(0, 1, 0, 8'd0);
      check_eq("abort_keeps_locked", {STATE, LOCKED, BUSY}, 5'b000_1_0);

      // Timeout
      begin_seq(8'd100, 32'hDEAD_BEEF);
      for (int w = 0; w < SW + TW - 1; w++) window(8'd0);
      check_eq("tmo_pre", STATE, 3'd2);
      window(8'd0);
      check_eq("tmo_failed", {STATE, fail_o, LOOP_BYPASS, BUSY}, 6'b101_1_1_0);
      check_eq("tmo_ncs", NO_CURRENT_SOURCE, 32'hDEAD_BEEF);
      begin_seq(8'd100, 32'hDEAD_BEEF);
      check_eq("tmo_restart", {STATE, fail_o}, 4'b001_0);
      cyc(0, 1, 0, 8'd0);

      // ABORT coincident with the lock-completing window
      begin_seq(8'd100, 32'h0F0F_0F0F);
      for (int w = 0; w < SW + CW + LW - 1; w++) window(8'd100);
      cyc(0, 1, 1, 8'd100);
      check_eq("abort_lock", {STATE, LOCKED}, 4'b000_0);

      // Asynchronous reset mid-COARSE
      begin_seq(8'd100, 32'hCAFE_F00D);
      for (int w = 0; w < SW + 2; w++) window(8'd100);
      check_eq("rst_pre_coarse", STATE, 3'd2);
      #2; RST_N = 0;
      #1;
      check_reset_values("arst");
      model_reset();
      @(posedge CLK); #3; RST_N = 1;
      cyc(0, 0, 0, 8'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
